// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-port (fetch/data) bus arbiter: FSM state
// encoding, owner encoding and the round-robin pick helper.
package bus_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // On a collision the port that did not win last time gets the bus.
  function automatic logic rr_pick(input logic fetch_req, input logic data_req,
                                   input logic last_owner);
    logic pick;
    if (fetch_req && data_req) begin
      pick = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (data_req) begin
      pick = OWN_D;
    end else begin
      pick = OWN_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: instruction-fetch burst reads and data-port single
// writes / burst reads share one request/ack bus with a beat-counted read phase.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rlast,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              last_owner;
  logic              we_q;
  logic              quiet;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  beat;
  logic              err_q;

  logic any_req;
  logic pick;
  logic grant;
  logic beat_hit;
  logic cnt_last;
  logic stray;
  logic mismatch;

  assign any_req  = i_req | d_req;
  assign pick     = rr_pick(i_req, d_req, last_owner);
  assign grant    = (state == ST_IDLE) && any_req && !reset;
  assign beat_hit = (state == ST_DATA) && bus_rvalid;
  assign cnt_last = (beat == LAST_BEAT);
  assign mismatch = beat_hit && (bus_rlast != cnt_last);
  // Leftover beats/acks of a transaction killed by reset are not errors.
  assign stray    = !quiet && ((bus_rvalid && (state != ST_DATA)) ||
                               (bus_ack && (state != ST_ADDR)));

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_ADDR;
        else         state_nxt = ST_IDLE;
      end
      ST_ADDR: begin
        if (bus_ack) state_nxt = we_q ? ST_DONE : ST_DATA;
        else         state_nxt = ST_ADDR;
      end
      ST_DATA: begin
        if (beat_hit && (bus_rlast || cnt_last)) state_nxt = ST_DONE;
        else                                     state_nxt = ST_DATA;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, latched request, beat counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      we_q       <= 1'b0;
      quiet      <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat       <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= pick;
        last_owner <= pick;
        quiet      <= 1'b0;
        we_q       <= (pick == OWN_D) ? d_we : 1'b0;
        addr_q     <= (pick == OWN_D) ? d_addr : i_addr;
        wdata_q    <= (pick == OWN_D) ? d_wdata : '0;
      end
      if ((state == ST_ADDR) && bus_ack) begin
        beat <= '0;
      end else if (beat_hit) begin
        beat <= beat + 1'b1;
      end
      if (stray || mismatch) begin
        err_q <= 1'b1;
      end
    end
  end

  assign i_gnt     = grant && (pick == OWN_I);
  assign d_gnt     = grant && (pick == OWN_D);
  assign i_rvalid  = beat_hit && (owner == OWN_I);
  assign d_rvalid  = beat_hit && (owner == OWN_D);
  assign i_done    = (state == ST_DONE) && (owner == OWN_I);
  assign d_done    = (state == ST_DONE) && (owner == OWN_D);
  assign rdata     = beat_hit ? bus_rdata : '0;
  assign bus_req   = (state == ST_ADDR);
  assign bus_we    = bus_req && we_q;
  assign bus_addr  = bus_req ? addr_q : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;
  assign proto_err = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, fetch burst,
// round-robin, single write, early rlast, reset mid-burst and stray beats.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [63:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done;
  logic [63:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic        bus_req, bus_we, bus_ack, bus_rvalid, bus_rlast, proto_err;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .BEATS(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_rlast(bus_rlast), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 64'h0; d_addr = 64'h0; d_wdata = 64'h0;
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_rdata = 64'h0;
  endtask

  // Two reset cycles; returns at posedge+1 with reset low.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, bus_req, bus_we, proto_err} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000000",
               {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, bus_req, bus_we, proto_err});
    end
    checks++;
    if ({bus_addr, bus_wdata, rdata} !== 192'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", bus_addr, bus_wdata, rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_ifetch_burst();
    int ngnt = 0, nrv = 0, nbad = 0, nother = 0, ndone = 0, done_at = -1, nhold = 0;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      i_req      = (c <= 12);
      i_addr     = 64'h1000;
      bus_ack    = (c == 3);
      bus_rvalid = (c >= 4) && (c <= 11);
      bus_rlast  = (c == 11);
      bus_rdata  = 64'hA000 + 64'(c);
      @(negedge clk);
      if ((c >= 1) && (c <= 3)) begin
        if (bus_req !== 1'b1 || bus_addr !== 64'h1000 || bus_we !== 1'b0) nhold++;
      end
      if (i_gnt) ngnt++;
      if (i_rvalid) begin
        nrv++;
        if (rdata !== 64'hA000 + 64'(c)) nbad++;
      end
      if (d_gnt || d_rvalid || d_done) nother++;
      if (i_done) begin ndone++; done_at = c; end
      @(posedge clk); #1;
    end
    checks++; if (nhold !== 0)   begin failures++; $display("FAIL fetch_addr_hold got=%0d exp=0", nhold); end
    checks++; if (ngnt !== 1)    begin failures++; $display("FAIL fetch_gnt_count got=%0d exp=1", ngnt); end
    checks++; if (nrv !== 8)     begin failures++; $display("FAIL fetch_rvalid_count got=%0d exp=8", nrv); end
    checks++; if (nbad !== 0)    begin failures++; $display("FAIL fetch_rdata got=%0d bad exp=0", nbad); end
    checks++; if (nother !== 0)  begin failures++; $display("FAIL fetch_dport_quiet got=%0d exp=0", nother); end
    checks++; if (ndone !== 1 || done_at !== 12) begin
      failures++; $display("FAIL fetch_done got=%0d@%0d exp=1@12", ndone, done_at);
    end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL fetch_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_round_robin();
    int nboth = 0;
    logic [1:0] gv;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      i_req      = 1'b1;
      i_addr     = 64'h4000;
      d_req      = !((c >= 3) && (c <= 13));
      d_we       = 1'b1;
      d_addr     = 64'h3000;
      d_wdata    = 64'h55;
      bus_ack    = (c == 1) || (c == 4) || (c == 15);
      bus_rvalid = (c >= 5) && (c <= 12);
      bus_rlast  = (c == 12);
      @(negedge clk);
      gv = {i_gnt, d_gnt};
      if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid) || (i_done && d_done)) nboth++;
      if (c == 0) begin
        checks++; if (gv !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", gv); end
      end
      if (c == 2) begin
        checks++; if (d_done !== 1'b1) begin failures++; $display("FAIL rr_d_done got=%b exp=1", d_done); end
      end
      if (c == 3) begin
        checks++; if (gv !== 2'b10) begin failures++; $display("FAIL rr_i_after_done got=%b exp=10", gv); end
      end
      if (c == 13) begin
        checks++; if (i_done !== 1'b1) begin failures++; $display("FAIL rr_i_done got=%b exp=1", i_done); end
      end
      if (c == 14) begin
        checks++; if (gv !== 2'b01) begin failures++; $display("FAIL rr_second got=%b exp=01", gv); end
      end
      if (c == 17) begin
        checks++; if (gv !== 2'b10) begin failures++; $display("FAIL rr_third got=%b exp=10", gv); end
      end
      @(posedge clk); #1;
    end
    checks++; if (nboth !== 0) begin failures++; $display("FAIL rr_exclusive got=%0d exp=0", nboth); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rr_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_write();
    int nwe = 0, nrv = 0, done_at = -1;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      d_req   = (c <= 2);
      d_we    = 1'b1;
      d_addr  = 64'h2000;
      d_wdata = 64'hDEADBEEF;
      bus_ack = (c == 1);
      @(negedge clk);
      if (bus_we) nwe++;
      if (i_rvalid || d_rvalid) nrv++;
      if (d_done) done_at = c;
      if (c == 1) begin
        checks++;
        if (bus_req !== 1'b1 || bus_wdata !== 64'hDEADBEEF || bus_addr !== 64'h2000) begin
          failures++; $display("FAIL wr_bus got=%b/%h/%h exp=1/deadbeef/2000", bus_req, bus_wdata, bus_addr);
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (nwe !== 1)     begin failures++; $display("FAIL wr_we_cycles got=%0d exp=1", nwe); end
    checks++; if (nrv !== 0)     begin failures++; $display("FAIL wr_no_rvalid got=%0d exp=0", nrv); end
    checks++; if (done_at !== 2) begin failures++; $display("FAIL wr_done_cycle got=%0d exp=2", done_at); end
  endtask

  task automatic test_early_rlast();
    int nrv = 0, done_at = -1, nerr = 0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      i_req      = (c <= 7);
      i_addr     = 64'h5000;
      bus_ack    = (c == 1);
      bus_rvalid = (c >= 2) && (c <= 6);
      bus_rlast  = (c == 6);
      bus_rdata  = 64'(c);
      @(negedge clk);
      if (i_rvalid) nrv++;
      if (i_done) done_at = c;
      if (c >= 7 && proto_err !== 1'b1) nerr++;
      if (c == 5) begin
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL early_err_before got=%b exp=0", proto_err); end
      end
      @(posedge clk); #1;
    end
    checks++; if (nrv !== 5)     begin failures++; $display("FAIL early_beats got=%0d exp=5", nrv); end
    checks++; if (done_at !== 7) begin failures++; $display("FAIL early_done_cycle got=%0d exp=7", done_at); end
    checks++; if (nerr !== 0)    begin failures++; $display("FAIL early_err_sticky got=%0d cycles low exp=0", nerr); end
  endtask

  task automatic test_reset_mid_burst();
    int nout = 0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      i_req      = (c <= 3);
      i_addr     = 64'h6000;
      reset      = (c == 4);
      bus_ack    = (c == 1);
      bus_rvalid = (c >= 2) && (c <= 9);
      bus_rlast  = (c == 9);
      bus_rdata  = 64'hBEEF0000 + 64'(c);
      @(negedge clk);
      if (c == 4) begin
        checks++; if (i_rvalid !== 1'b1) begin failures++; $display("FAIL rst_beat3_seen got=%b exp=1", i_rvalid); end
      end
      if (c >= 5) begin
        if ({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, bus_req, bus_we, proto_err} !== 9'b0 ||
            rdata !== 64'h0 || bus_addr !== 64'h0) nout++;
      end
      @(posedge clk); #1;
    end
    checks++; if (nout !== 0) begin failures++; $display("FAIL rst_outputs_quiet got=%0d cycles exp=0", nout); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_stray_beat();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      d_req      = (c <= 2);
      d_we       = 1'b1;
      d_addr     = 64'h7000;
      bus_ack    = (c == 1);
      bus_rvalid = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || proto_err !== 1'b0) begin
          failures++; $display("FAIL stray_ignored got=%b%b%b exp=000", i_rvalid, d_rvalid, proto_err);
        end
      end
      if (c == 5) begin
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL stray_sets_err got=%b exp=1", proto_err); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_ifetch_burst();
    test_round_robin();
    test_write();
    test_early_rlast();
    test_reset_mid_burst();
    test_stray_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 64, meaning bus address width.
REQ-002 The module SHALL have parameter DATA_W, default 64, meaning bus data width.
REQ-003 The module SHALL have parameter BEATS, default 8, meaning read burst length in beats (power of two, 2..16).
REQ-004 The module SHALL have a single clock; reset is synchronous and active-high; ports as follows.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction-fetch read request
- i_addr  in  ADDR_W  fetch burst address
- i_gnt  out  1  fetch owns bus (pulse, 1 cycle)
- i_rvalid  out  1  fetch read beat valid
- i_done  out  1  fetch transaction complete (1-cycle pulse)
- d_req  in  1  data-memory request
- d_we  in  1  1=single-beat write, 0=burst read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt, d_rvalid, d_done  out  1 each  as i_* for the data port
- rdata  out  DATA_W  read beat data, shared by both ports
- bus_req  out  1  request valid on bus
- bus_we  out  1  write request
- bus_addr  out  ADDR_W  request address
- bus_wdata  out  DATA_W  write data
- bus_ack  in  1  bus accepted request this cycle
- bus_rvalid  in  1  read beat valid
- bus_rdata  in  DATA_W  read beat data
- bus_rlast  in  1  final read beat
- proto_err  out  1  sticky protocol-error flag

Function
REQ-005 The arbiter SHALL be an FSM with states IDLE, ADDR, DATA, DONE.
REQ-006 In IDLE with any req high, it SHALL latch the owner, address, we and wdata, pulse that port's gnt, and enter ADDR next cycle.
REQ-007 When both requests are high in IDLE, it SHALL grant the port not granted last (round-robin); after reset the data port wins first.
REQ-008 In ADDR, bus_req SHALL be 1 with latched bus_we/bus_addr/bus_wdata held stable until the cycle bus_ack=1.
REQ-009 On bus_ack in ADDR: a write SHALL go to DONE; a read SHALL go to DATA with beat counter cleared.
REQ-010 In DATA, each bus_rvalid SHALL drive the owner's rvalid=1 with rdata=bus_rdata combinationally (zero latency); the other port's rvalid stays 0.
REQ-011 The beat counter SHALL increment per bus_rvalid; DATA SHALL exit to DONE on the beat where bus_rlast=1 or the counter equals BEATS-1.
REQ-012 If bus_rlast and counter==BEATS-1 disagree on a beat, proto_err SHALL set and remain 1 until reset; the FSM still exits to DONE.
REQ-013 bus_rvalid or bus_ack outside their expected states SHALL be ignored and SHALL set proto_err.
REQ-014 DONE SHALL last exactly one cycle, pulse the owner's done, and return to IDLE; a new grant is possible on the cycle after DONE.
REQ-015 Requests SHALL be level-held by requesters until done; dropping req mid-transaction SHALL NOT abort it.
REQ-016 bus_req SHALL be 0 in every state except ADDR; gnt/rvalid/done SHALL never be high for both ports in one cycle.
REQ-017 Minimum read transaction: gnt cycle 0, bus_req cycle 1, ack cycle 1 earliest, beats cycles 2..BEATS+1, done cycle BEATS+2.

Reset
REQ-018 reset SHALL force IDLE, beat counter 0, round-robin pointer to "data next", proto_err 0, and all outputs 0 on the following cycle, including mid-burst; remaining beats are then ignored without setting proto_err until the next grant.

Structure
REQ-019 The FSM state enum and owner encoding (OWN_I, OWN_D) SHALL live in the shared core package.
REQ-020 The design SHALL be a single module with no sub-modules; counter width is $clog2(BEATS).

Verification
REQ-021 i_req only, addr 0x1000, ack after 2 wait cycles, 8 beats with rlast on 8th -> i_gnt once, 8 i_rvalid, i_done one cycle after last beat, proto_err=0.
REQ-022 i_req and d_req same cycle after reset -> d_gnt first; after d_done, i_gnt on the cycle after DONE; next collision -> d wins again only if i won last.
REQ-023 d_req write, d_wdata 0xDEADBEEF, ack immediate -> bus_we=1 for one cycle, d_done next cycle, no rvalid.
REQ-024 Read burst with bus_rlast on beat 5 of 8 -> DONE after beat 5, proto_err=1 and stays 1.
REQ-025 reset asserted during beat 3 of a burst -> IDLE next cycle, all outputs 0, subsequent stray beats ignored, proto_err=0.
